// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Build with REG_DUMP_FRAMING_EN to add the 0xA5 header and XOR checksum bytes.
package reg_dump_pkg;

  localparam int DUMP_NB_DATA     = 32;
  localparam int DUMP_NB_BYTE     = 8;
  localparam int BYTES_PER_WORD   = DUMP_NB_DATA / DUMP_NB_BYTE;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND,
    NEXT,
    DONE
`ifdef REG_DUMP_FRAMING_EN
    , HDR,
    CHK
`endif
  } state_t;

endpackage

// File: rtl/reg_dump_reader_word_byte_serializer.sv
// Loads one word and emits it MSB byte first over valid/ready; last marks the final accepted byte.
// With single set at load, only the top byte is sent (used for framing bytes).
module word_byte_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               single,
  input  logic [NB_DATA-1:0] word,
  input  logic               ready,
  output logic [NB_BYTE-1:0] data,
  output logic               valid,
  output logic               last
);

  localparam int BPW    = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shift;
  logic [NB_CNT-1:0]  count;

  assign data = shift[NB_DATA-1 -: NB_BYTE];
  assign last = valid && ready && (count == CNT_LAST);

  // valid is purely registered so it never follows ready combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      shift <= '0;
      count <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shift <= word;
      count <= single ? CNT_LAST : '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (count == CNT_LAST) begin
        shift <= '0;
        count <= '0;
        valid <= 1'b0;
      end else begin
        shift <= shift << NB_BYTE;
        count <= count + NB_CNT'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug dump of the 32x32 register file: walks every address and streams the words as bytes to UART TX.
// Optional REG_DUMP_FRAMING_EN adds a 0xA5 header byte and a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for i_start, all outputs low
// HDR   | sending header byte (framing builds only)
// ADDR  | address presented, register file read data settles on negedge
// LOAD  | word captured into the serializer
// SEND  | bytes streaming out under valid/ready
// NEXT  | advance index or finish
// CHK   | sending checksum byte (framing builds only)
// DONE  | one-cycle o_done pulse
module reg_dump_reader #(
  parameter int NB_DATA = reg_dump_pkg::DUMP_NB_DATA,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = reg_dump_pkg::DUMP_NB_BYTE
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_rf_data,
  output logic [NB_ADDR-1:0] o_rf_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  import reg_dump_pkg::*;

  localparam logic [NB_ADDR-1:0] LAST_INDEX = NB_ADDR'(N_REGS - 1);

  state_t             state;
  logic [NB_ADDR-1:0] index;
  logic               ser_load;
  logic               ser_single;
  logic               ser_last;
  logic [NB_DATA-1:0] ser_word;

`ifdef REG_DUMP_FRAMING_EN
  logic [NB_BYTE-1:0] chk;
`endif

  always_comb begin
    ser_load   = (state == LOAD);
    ser_single = 1'b0;
    ser_word   = i_rf_data;
`ifdef REG_DUMP_FRAMING_EN
    // framing bytes reuse the serializer as single-byte words
    if (state == IDLE && i_start) begin
      ser_load   = 1'b1;
      ser_single = 1'b1;
      ser_word   = NB_DATA'(HEADER_BYTE) << (NB_DATA - NB_BYTE);
    end else if (state == NEXT && index == LAST_INDEX) begin
      ser_load   = 1'b1;
      ser_single = 1'b1;
      ser_word   = NB_DATA'(chk) << (NB_DATA - NB_BYTE);
    end
`endif
  end

  word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk    (clk),
    .reset  (i_reset),
    .load   (ser_load),
    .single (ser_single),
    .word   (ser_word),
    .ready  (i_tx_ready),
    .data   (o_tx_data),
    .valid  (o_tx_valid),
    .last   (ser_last)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= IDLE;
      index     <= '0;
      o_rf_addr <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            index     <= '0;
            o_rf_addr <= '0;
            o_busy    <= 1'b1;
`ifdef REG_DUMP_FRAMING_EN
            state     <= HDR;
`else
            state     <= ADDR;
`endif
          end
        end
        ADDR: state <= LOAD;
        LOAD: state <= SEND;
        SEND: if (ser_last) state <= NEXT;
        NEXT: begin
          if (index == LAST_INDEX) begin
            o_rf_addr <= '0;
`ifdef REG_DUMP_FRAMING_EN
            state     <= CHK;
`else
            state     <= DONE;
            o_done    <= 1'b1;
`endif
          end else begin
            index     <= index + NB_ADDR'(1);
            o_rf_addr <= index + NB_ADDR'(1);
            state     <= ADDR;
          end
        end
`ifdef REG_DUMP_FRAMING_EN
        HDR: if (ser_last) state <= ADDR;
        CHK: begin
          if (ser_last) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
`endif
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_DUMP_FRAMING_EN
  always_ff @(posedge clk) begin
    if (i_reset) begin
      chk <= '0;
    end else if (state == IDLE && i_start) begin
      chk <= '0;
    end else if (state == SEND && o_tx_valid && i_tx_ready) begin
      chk <= chk ^ o_tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register file model with negedge read data, byte-stream reference model.
// Honours REG_DUMP_FRAMING_EN for the expected header/checksum bytes.
module tb_reg_dump_reader;

`ifdef REG_DUMP_FRAMING_EN
  localparam int FR = 1;
`else
  localparam int FR = 0;
`endif
  localparam int NBYTES = 128 + 2 * FR;
  localparam int DONE_CYC = 225 + 2 * FR;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_rf_data = '0;
  logic [4:0]  o_rf_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [32];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int stall_err = 0;
  int stalls_seen = 0;
  int rdy_mode = 0;
  int rdy_cnt = 0;

  reg_dump_reader dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_rf_data  (i_rf_data),
    .o_rf_addr  (o_rf_addr),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial forever #5 clk = ~clk;

  // register file read data changes on negedge
  initial forever begin
    @(negedge clk);
    i_rf_data = rf[o_rf_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: i_tx_ready = 1'b1;
      1: begin
        i_tx_ready = (rdy_cnt % 3 == 0);
        rdy_cnt++;
      end
      default: i_tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // byte collector and hold-while-stalled tracker
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stall_err++;
      if (o_tx_valid === 1'b1 && i_tx_ready) got.push_back(o_tx_data);
      prev_stall = (o_tx_valid === 1'b1) && !i_tx_ready;
      prev_data = o_tx_data;
      if (prev_stall) stalls_seen++;
    end
  end

  task automatic fill_pattern();
    for (int k = 0; k < 32; k++) rf[k] = 32'h0100_0000 * k + k;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
  endtask

  task automatic build_expected();
    logic [7:0] x;
    logic [7:0] bt;
    x = '0;
    exp_q.delete();
    if (FR == 1) exp_q.push_back(8'hA5);
    for (int k = 0; k < 32; k++) begin
      for (int b = 3; b >= 0; b--) begin
        bt = rf[k][8*b +: 8];
        exp_q.push_back(bt);
        x = x ^ bt;
      end
    end
    if (FR == 1) exp_q.push_back(x);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  task automatic start_pulse();
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic run_dump(input int max_cyc, input int wr_cyc, input logic [31:0] wr_val,
                          input bit extra_starts, output int done_cyc, output int n_done,
                          output bit busy_gap, output bit busy_after);
    int cyc;
    got.delete();
    done_cyc = 0;
    n_done = 0;
    busy_gap = 0;
    busy_after = 0;
    cyc = 0;
    start_pulse();
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      if (extra_starts && (cyc == 5 || cyc == 50 || cyc == 224 || cyc == 225)) i_start = 1'b1;
      if (cyc == wr_cyc) rf[31] = wr_val;
      if (n_done == 0 && o_busy !== 1'b1) busy_gap = 1;
      if (n_done > 0 && o_busy !== 1'b0) busy_after = 1;
      if (o_done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (n_done > 0 && cyc >= done_cyc + 10) break;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({o_busy, o_done, o_tx_valid} !== 3'b000) $display("FAIL reset_ctrl: busy/done/valid=%b want 000", {o_busy, o_done, o_tx_valid});
    else pass_cnt++;
    total_cnt++;
    if (o_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", o_tx_data);
    else pass_cnt++;
    total_cnt++;
    if (o_rf_addr !== 5'd0) $display("FAIL reset_rf_addr: got %0d want 0", o_rf_addr);
    else pass_cnt++;
    @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL idle_no_start: busy=%b want 0", o_busy);
    else pass_cnt++;
  endtask

  task automatic test_full_dump();
    int dc, nd, d;
    bit bg, ba;
    logic [15:0] v;
    rdy_mode = 0;
    fill_pattern();
    build_expected();
    run_dump(600, -1, 32'h0, 0, dc, nd, bg, ba);
    total_cnt++;
    if (dc !== DONE_CYC) $display("FAIL full_done_cycle: got %0d want %0d", dc, DONE_CYC);
    else pass_cnt++;
    total_cnt++;
    if (nd !== 1) $display("FAIL full_done_count: got %0d want 1", nd);
    else pass_cnt++;
    total_cnt++;
    if ({bg, ba} !== 2'b00) $display("FAIL full_busy: gap/after=%b want 00", {bg, ba});
    else pass_cnt++;
    total_cnt++;
    if (got.size() !== NBYTES) $display("FAIL full_byte_count: got %0d want %0d", got.size(), NBYTES);
    else pass_cnt++;
    d = first_diff();
    total_cnt++;
    if (d != -1) $display("FAIL full_stream: first diff at byte %0d", d);
    else pass_cnt++;
    v = (got.size() > FR + 7) ? {got[FR+4], got[FR+7]} : 16'hxxxx;
    total_cnt++;
    if (v !== 16'h0101) $display("FAIL full_reg1_bytes: got %h want 0101", v);
    else pass_cnt++;
    total_cnt++;
    if ({o_tx_valid, o_rf_addr} !== 6'd0) $display("FAIL full_idle_after: valid/addr=%h want 0", {o_tx_valid, o_rf_addr});
    else pass_cnt++;
  endtask

  task automatic test_ready_throttle();
    int dc, nd, d;
    bit bg, ba;
    rdy_mode = 1;
    rdy_cnt = 0;
    stall_err = 0;
    stalls_seen = 0;
    fill_pattern();
    build_expected();
    run_dump(3000, -1, 32'h0, 0, dc, nd, bg, ba);
    rdy_mode = 0;
    d = first_diff();
    total_cnt++;
    if (d != -1) $display("FAIL throttle_stream: first diff at byte %0d (got %0d bytes)", d, got.size());
    else pass_cnt++;
    total_cnt++;
    if (stall_err !== 0) $display("FAIL throttle_hold: %0d unstable stalls want 0", stall_err);
    else pass_cnt++;
    total_cnt++;
    if ((stalls_seen > 0) !== 1'b1) $display("FAIL throttle_stalls: saw %0d stalls want >0", stalls_seen);
    else pass_cnt++;
    total_cnt++;
    if ({nd, bg} !== {32'd1, 1'b0}) $display("FAIL throttle_done: done_count=%0d busy_gap=%b want 1/0", nd, bg);
    else pass_cnt++;
  endtask

  task automatic test_random_back_to_back();
    int dc, nd, d;
    bit bg, ba;
    rdy_mode = 2;
    stall_err = 0;
    for (int r = 0; r < 2; r++) begin
      fill_random();
      build_expected();
      run_dump(3000, -1, 32'h0, 0, dc, nd, bg, ba);
      d = first_diff();
      total_cnt++;
      if (d != -1) $display("FAIL random_stream_%0d: first diff at byte %0d (got %0d bytes)", r, d, got.size());
      else pass_cnt++;
      total_cnt++;
      if (nd !== 1) $display("FAIL random_done_%0d: got %0d want 1", r, nd);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_err !== 0) $display("FAIL random_hold: %0d unstable stalls want 0", stall_err);
    else pass_cnt++;
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_dump();
    int dc, nd, d;
    bit bg, ba;
    rdy_mode = 0;
    fill_random();
    build_expected();
    got.delete();
    start_pulse();
    for (int c = 1; c <= 74 + FR; c++) @(negedge clk);
    @(posedge clk);
    #1 i_reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({o_tx_valid, o_tx_data} !== {1'b1, rf[10][15:8]})
      $display("FAIL midrst_position: valid/data=%b/%h want 1/%h", o_tx_valid, o_tx_data, rf[10][15:8]);
    else pass_cnt++;
    total_cnt++;
    if (got.size() !== 42 + FR) $display("FAIL midrst_accepted: got %0d want %0d", got.size(), 42 + FR);
    else pass_cnt++;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({o_tx_valid, o_busy, o_done, o_rf_addr} !== 8'd0)
      $display("FAIL midrst_outputs: valid=%b busy=%b done=%b addr=%0d want all 0", o_tx_valid, o_busy, o_done, o_rf_addr);
    else pass_cnt++;
    run_dump(600, -1, 32'h0, 0, dc, nd, bg, ba);
    d = first_diff();
    total_cnt++;
    if (d != -1) $display("FAIL midrst_restart: first diff at byte %0d", d);
    else pass_cnt++;
    total_cnt++;
    if (dc !== DONE_CYC) $display("FAIL midrst_done_cycle: got %0d want %0d", dc, DONE_CYC);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int dc, nd, d;
    bit bg, ba;
    rdy_mode = 0;
    fill_random();
    build_expected();
    run_dump(600, -1, 32'h0, 1, dc, nd, bg, ba);
    total_cnt++;
    if (nd !== 1) $display("FAIL ignstart_done_count: got %0d want 1", nd);
    else pass_cnt++;
    total_cnt++;
    if (got.size() !== NBYTES) $display("FAIL ignstart_byte_count: got %0d want %0d", got.size(), NBYTES);
    else pass_cnt++;
    d = first_diff();
    total_cnt++;
    if (d != -1) $display("FAIL ignstart_stream: first diff at byte %0d", d);
    else pass_cnt++;
    total_cnt++;
    if ({bg, ba} !== 2'b00) $display("FAIL ignstart_busy: gap/after=%b want 00", {bg, ba});
    else pass_cnt++;
  endtask

  task automatic test_midwrite();
    int dc, nd, d;
    bit bg, ba;
    logic [31:0] tail;
    rdy_mode = 0;
    fill_random();
    run_dump(600, 23 + FR, 32'hDEAD_BEEF, 0, dc, nd, bg, ba);
    build_expected();
    tail = (got.size() >= FR + 128) ? {got[FR+124], got[FR+125], got[FR+126], got[FR+127]} : 32'hxxxx_xxxx;
    total_cnt++;
    if (tail !== 32'hDEAD_BEEF) $display("FAIL midwrite_tail: got %h want deadbeef", tail);
    else pass_cnt++;
    d = first_diff();
    total_cnt++;
    if (d != -1) $display("FAIL midwrite_stream: first diff at byte %0d", d);
    else pass_cnt++;
  endtask

`ifdef REG_DUMP_FRAMING_EN
  task automatic test_framing();
    int dc, nd;
    bit bg, ba;
    logic [15:0] ends;
    rdy_mode = 0;
    for (int k = 0; k < 32; k++) rf[k] = '0;
    rf[1] = 32'h0000_00FF;
    run_dump(600, -1, 32'h0, 0, dc, nd, bg, ba);
    ends = (got.size() > 0) ? {got[0], got[got.size()-1]} : 16'hxxxx;
    total_cnt++;
    if (ends !== 16'hA5FF) $display("FAIL framing_ends: first/last=%h want a5ff", ends);
    else pass_cnt++;
    total_cnt++;
    if (got.size() !== 130) $display("FAIL framing_count: got %0d want 130", got.size());
    else pass_cnt++;
  endtask
`endif

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = '0;
    test_reset();
    test_full_dump();
    test_ready_throttle();
    test_random_back_to_back();
    test_reset_mid_dump();
    test_start_ignored();
    test_midwrite();
`ifdef REG_DUMP_FRAMING_EN
    test_framing();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side debug client of the CPU's 32x32 register file; drives a register file read port instead of the decode stage.
- On a start pulse, walks addresses 0..31, captures each word and serializes it as bytes to the UART transmitter over a valid/ready handshake.
- Sits in the debug unit between the register file read port and the UART TX.

Parameters:
- NB_DATA, 32, register word width.
- NB_ADDR, 5, register address width.
- N_REGS, 32, number of registers dumped.
- NB_BYTE, 8, TX byte width; NB_DATA must be a multiple of NB_BYTE.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start request.
- i_rf_data  in  NB_DATA  register file read data for o_rf_addr.
- o_rf_addr  out  NB_ADDR  register file read address.
- o_tx_data  out  NB_BYTE  byte to transmitter.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  transmitter accepts byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse at end of dump.

Behaviour:
- Reset: state IDLE, o_rf_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, index=0, byte count=0. Reset mid-dump aborts immediately; o_tx_valid drops the next cycle; no partial resume.
- FSM states: IDLE, ADDR, LOAD, SEND, NEXT, DONE.
- IDLE: on i_start go to ADDR with index=0. All outputs low.
- ADDR: o_rf_addr=index. Hold one full cycle, because the register file updates read data on negedge.
- LOAD: capture i_rf_data into the shift register; byte count=0; go to SEND.
- SEND: o_tx_valid=1, o_tx_data = current byte, MSB byte first (bits 31:24 first). Handshake completes on a cycle with valid && ready.
  - If count == NB_DATA/NB_BYTE-1, go to NEXT.
  - Otherwise shift left by NB_BYTE and increment count.
  - While valid && !ready: o_tx_data and o_tx_valid held stable.
  - Valid never depends combinationally on ready.
- NEXT: if index == N_REGS-1, go to DONE; otherwise index+1 and go to ADDR.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- i_start while busy is ignored. i_start in the same cycle as o_done is ignored; a new start is accepted only from IDLE.
- Writes to the register file during a dump are not blocked. Each word is sampled in its LOAD cycle.
- Throughput with ready held high: 1 (ADDR) + 1 (LOAD) + 4 (SEND) + 1 (NEXT) cycles per word. A full dump is 32*7+1 = 225 cycles start-to-done, 128 bytes.
- Index and byte counters never wrap inside a dump; index is reset to 0 on each start.

Optional Feature:
- Macro REG_DUMP_FRAMING_EN.
- Defined:
  - Adds state HDR before the first ADDR, which sends byte 0xA5.
  - Adds state CHK after the last word, before DONE, which sends the XOR of all 128 data bytes.
  - Both use the same handshake rules. The checksum accumulator clears on start.
  - Total 130 bytes.
- Undefined: no HDR/CHK states and no accumulator logic; 128 bytes.

Decomposition:
- Package reg_dump_pkg holds:
  - state encoding typedef;
  - BYTES_PER_WORD = NB_DATA/NB_BYTE;
  - HEADER_BYTE = 8'hA5.
- One natural sub-module: word_byte_serializer.
  - Loads a word, emits BYTES_PER_WORD bytes MSB-first under valid/ready, pulses last.
  - Controlled by the top FSM.

Test Plan:
- Preload reg[k] = 32'h0100_0000*k + k; pulse i_start, ready held high -> 128 bytes in order 00 00 00 00, 01 00 00 01, ...; o_done on cycle 225 after start; o_busy high throughout.
- Toggle ready 1-of-3 cycles -> identical byte stream; o_tx_data stable while valid && !ready; no byte lost or duplicated.
- Reset asserted during SEND of reg 10, byte 2 -> next cycle o_tx_valid=0, o_busy=0, o_rf_addr=0; a following i_start restarts from reg 0.
- i_start pulsed at cycles 5, 50 and 224 of a dump -> ignored; exactly one o_done and 128 bytes.
- Write reg 31 = 32'hDEADBEEF mid-dump (while dumping reg 3) -> last 4 bytes are DE AD BE EF.
- With REG_DUMP_FRAMING_EN and all registers 0 except reg 1 = 32'h0000_00FF -> first byte A5, last byte FF, 130 bytes total.
